// File: rtl/video_pkg.sv
// Shared types and constants for the video controller.
// No logic, so no latency.
// No flow control; constants and the bar-colour lookup only.
package video_pkg;

   typedef logic [23:0] rgb_t;

   // Default raster geometry (800x480 panel timing)
   localparam int DEF_HDISP     = 800;
   localparam int DEF_VDISP     = 480;
   localparam int DEF_HFP       = 40;
   localparam int DEF_HPULSE    = 40;
   localparam int DEF_HBP       = 40;
   localparam int DEF_VFP       = 13;
   localparam int DEF_VPULSE    = 3;
   localparam int DEF_VBP       = 29;
   localparam int DEF_BLINK_DIV = 25_000_000;

   // Colour-bar palette, left to right
   localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
   localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
   localparam rgb_t BAR_CYAN    = 24'h00FFFF;
   localparam rgb_t BAR_GREEN   = 24'h00FF00;
   localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
   localparam rgb_t BAR_RED     = 24'hFF0000;
   localparam rgb_t BAR_BLUE    = 24'h0000FF;
   localparam rgb_t BAR_BLACK   = 24'h000000;

   // Map a bar index (0 = leftmost) to its colour
   function automatic rgb_t bar_colour(input logic [2:0] idx);
      rgb_t c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/hws_if.sv
// Hardware-support bridge bundle: simple address/read/write bus.
// Pure wiring, no latency.
// Slave stalls the master with WAITREQUEST.
interface hws_if;
   logic [15:0] ADDRESS;
   logic        READ;
   logic        WRITE;
   logic [31:0] WRITEDATA;
   logic [31:0] READDATA;
   logic        WAITREQUEST;

   modport master (output ADDRESS, READ, WRITE, WRITEDATA,
                   input  READDATA, WAITREQUEST);
   modport slave  (input  ADDRESS, READ, WRITE, WRITEDATA,
                   output READDATA, WAITREQUEST);
endinterface

// File: rtl/video_if.sv
// Video output bundle: pixel clock, syncs, blank and 24-bit colour.
// Pure wiring, no latency.
// No backpressure; the sink must accept one pixel per clock.
interface video_if;
   import video_pkg::*;

   logic CLK;
   logic HS;
   logic VS;
   logic BLANK;
   rgb_t RGB;

   modport master (output CLK, HS, VS, BLANK, RGB);
   modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_timing.sv
// Raster x/y counters with registered HS/VS/BLANK and live active coordinates.
// HS/VS/BLANK lag the counters by 1 cycle; px/py/active are combinational.
// Free-running, no backpressure.
module vga_timing import video_pkg::*; #(
   parameter int HDISP  = DEF_HDISP,
   parameter int VDISP  = DEF_VDISP,
   parameter int HFP    = DEF_HFP,
   parameter int HPULSE = DEF_HPULSE,
   parameter int HBP    = DEF_HBP,
   parameter int VFP    = DEF_VFP,
   parameter int VPULSE = DEF_VPULSE,
   parameter int VBP    = DEF_VBP
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic hs_o,
   output logic vs_o,
   output logic blank_o,
   output logic active_o,
   output logic frame_wrap_o,
   output logic [$clog2(HFP+HPULSE+HBP+HDISP)-1:0] px_o,
   output logic [$clog2(VFP+VPULSE+VBP+VDISP)-1:0] py_o
);

   localparam int HTOT = HFP + HPULSE + HBP + HDISP;
   localparam int VTOT = VFP + VPULSE + VBP + VDISP;
   localparam int HW   = $clog2(HTOT);
   localparam int VW   = $clog2(VTOT);

   // All boundaries are below HTOT/VTOT, so they fit the counter widths
   localparam logic [HW-1:0] X_LAST = HW'(HTOT - 1);
   localparam logic [HW-1:0] HS_BEG = HW'(HFP);
   localparam logic [HW-1:0] HS_END = HW'(HFP + HPULSE);
   localparam logic [HW-1:0] X_ACT  = HW'(HFP + HPULSE + HBP);
   localparam logic [VW-1:0] Y_LAST = VW'(VTOT - 1);
   localparam logic [VW-1:0] VS_BEG = VW'(VFP);
   localparam logic [VW-1:0] VS_END = VW'(VFP + VPULSE);
   localparam logic [VW-1:0] Y_ACT  = VW'(VFP + VPULSE + VBP);

   logic [HW-1:0] x_q, x_d;
   logic [VW-1:0] y_q, y_d;
   logic          hs_q, vs_q, blank_q;
   logic          hs_d, vs_d, active;
   logic          x_last, y_last;

   // Counter advance and sync/active decode from the current counter values
   always_comb begin
      x_last = (x_q == X_LAST);
      y_last = (y_q == Y_LAST);
      x_d    = x_last ? '0 : x_q + HW'(1);
      y_d    = y_q;
      if (x_last) begin
         y_d = y_last ? '0 : y_q + VW'(1);
      end
      hs_d   = !((x_q >= HS_BEG) && (x_q < HS_END));
      vs_d   = !((y_q >= VS_BEG) && (y_q < VS_END));
      active = (x_q >= X_ACT) && (y_q >= Y_ACT);
   end

   // Counter state and one-cycle registered sync/blank outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q     <= '0;
         y_q     <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= active;
      end
   end

   assign hs_o         = hs_q;
   assign vs_o         = vs_q;
   assign blank_o      = blank_q;
   assign active_o     = active;
   assign frame_wrap_o = x_last & y_last;
   // Only meaningful while active; wraps harmlessly elsewhere
   assign px_o         = x_q - X_ACT;
   assign py_o         = y_q - Y_ACT;

endmodule

// File: rtl/video_ctrl_top.sv
// Video controller top: raster timing, test-pattern generator, status LEDs.
// Video outputs lag the raster counters by 1 cycle; LEDs are registered.
// No backpressure: one pixel per clock; the support bus is held idle.
module video_ctrl_top import video_pkg::*; #(
   parameter int HDISP     = DEF_HDISP,
   parameter int VDISP     = DEF_VDISP,
   parameter int HFP       = DEF_HFP,
   parameter int HPULSE    = DEF_HPULSE,
   parameter int HBP       = DEF_HBP,
   parameter int VFP       = DEF_VFP,
   parameter int VPULSE    = DEF_VPULSE,
   parameter int VBP       = DEF_VBP,
   parameter int BLINK_DIV = DEF_BLINK_DIV
) (
   input  logic        FPGA_CLK1_50,
   input  logic [1:0]  KEY,
   input  logic [3:0]  SW,
   output logic [7:0]  LED,
   hws_if.master       hws_ifm,
   video_if.master     video_ifm
);

   localparam int HTOT  = HFP + HPULSE + HBP + HDISP;
   localparam int VTOT  = VFP + VPULSE + VBP + VDISP;
   localparam int HW    = $clog2(HTOT);
   localparam int VW    = $clog2(VTOT);
   localparam int BAR_W = (HDISP / 8 > 0) ? HDISP / 8 : 1;
   localparam int BW    = $clog2(BLINK_DIV + 1);

   logic          rst;
   logic          hs, vs, blank, active, frame_wrap;
   logic [HW-1:0] px, bar_full;
   logic [VW-1:0] py;
   logic [2:0]    bar_idx;
   rgb_t          rgb_q, rgb_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          led0_q, led0_d, led1_q, led1_d;
   logic [3:0]    sw_q;
   logic          unused_ok;

   assign rst = ~KEY[0];

   vga_timing #(
      .HDISP (HDISP),  .VDISP (VDISP),
      .HFP   (HFP),    .HPULSE(HPULSE), .HBP(HBP),
      .VFP   (VFP),    .VPULSE(VPULSE), .VBP(VBP)
   ) u_timing (
      .clk_i       (FPGA_CLK1_50),
      .rst_i       (rst),
      .hs_o        (hs),
      .vs_o        (vs),
      .blank_o     (blank),
      .active_o    (active),
      .frame_wrap_o(frame_wrap),
      .px_o        (px),
      .py_o        (py)
   );

   // Pattern select: grid lines every 16 pixels or eight vertical bars
   always_comb begin
      bar_full = px / HW'(BAR_W);
      bar_idx  = (bar_full > HW'(7)) ? 3'd7 : bar_full[2:0];
      rgb_d    = '0;
      if (active) begin
         if (SW[0]) begin
            rgb_d = bar_colour(bar_idx);
         end else if ((px[3:0] == 4'd0) || (py[3:0] == 4'd0)) begin
            rgb_d = BAR_WHITE;
         end
      end
   end

   // Colour register, aligned with the registered syncs in the timing block
   always_ff @(posedge FPGA_CLK1_50) begin
      if (rst) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= rgb_d;
      end
   end

   // LED next state: blink divider wrap and once-per-frame toggle
   always_comb begin
      blink_d = blink_q + BW'(1);
      led0_d  = led0_q;
      led1_d  = led1_q;
      if (blink_q == BW'(BLINK_DIV - 1)) begin
         blink_d = '0;
         led0_d  = ~led0_q;
      end
      if (frame_wrap) begin
         led1_d = ~led1_q;
      end
   end

   // LED state and switch mirror
   always_ff @(posedge FPGA_CLK1_50) begin
      if (rst) begin
         blink_q <= '0;
         led0_q  <= 1'b0;
         led1_q  <= 1'b0;
         sw_q    <= '0;
      end else begin
         blink_q <= blink_d;
         led0_q  <= led0_d;
         led1_q  <= led1_d;
         sw_q    <= SW;
      end
   end

   assign LED = {sw_q, 2'b00, led1_q, led0_q};

   assign video_ifm.CLK   = FPGA_CLK1_50;
   assign video_ifm.HS    = hs;
   assign video_ifm.VS    = vs;
   assign video_ifm.BLANK = blank;
   assign video_ifm.RGB   = rgb_q;

   // Support bridge is present for board compatibility but never issues a cycle
   assign hws_ifm.ADDRESS   = '0;
   assign hws_ifm.READ      = 1'b0;
   assign hws_ifm.WRITE     = 1'b0;
   assign hws_ifm.WRITEDATA = '0;

   assign unused_ok = &{1'b0, KEY[1], py, hws_ifm.READDATA, hws_ifm.WAITREQUEST};

endmodule

// File: tb/tb_video_ctrl_top.sv
// Directed bench for video_ctrl_top with a 160x90 raster (HTOT=280, VTOT=135).
// t counts rising edges since the last reset release; outputs sampled at negedge.
module tb_video_ctrl_top;
   import video_pkg::*;

   localparam int HDISP = 160;
   localparam int VDISP = 90;
   localparam int BLINK = 10;

   logic       clk = 1'b0;
   logic [1:0] key;
   logic [3:0] sw;
   logic [7:0] led;

   int checks        = 0;
   int failures      = 0;
   int t             = 0;
   int blank_cnt     = 0;
   int blank_rgb_bad = 0;

   hws_if   hws ();
   video_if vid ();

   video_ctrl_top #(
      .HDISP    (HDISP),
      .VDISP    (VDISP),
      .BLINK_DIV(BLINK)
   ) dut (
      .FPGA_CLK1_50(clk),
      .KEY         (key),
      .SW          (sw),
      .LED         (led),
      .hws_ifm     (hws),
      .video_ifm   (vid)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      t++;
      if (vid.BLANK === 1'b1) blank_cnt++;
      else if (vid.RGB !== 24'h0) blank_rgb_bad++;
   endtask

   task automatic run_to(input int target);
      while (t < target) tick();
   endtask

   function automatic logic pick(input int sel);
      case (sel)
         0:       return vid.HS;
         1:       return vid.VS;
         default: return vid.BLANK;
      endcase
   endfunction

   task automatic wait_for(input int sel, input logic val, input int bound, input string tag);
      int n = 0;
      while (pick(sel) !== val && n < bound) begin
         tick();
         n++;
      end
      check(tag, {31'b0, pick(sel)}, {31'b0, val});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_hs"},    vid.HS,    1);
      check({tag, "_vs"},    vid.VS,    1);
      check({tag, "_blank"}, vid.BLANK, 0);
      check({tag, "_rgb"},   vid.RGB,   0);
      check({tag, "_led"},   led,       0);
   endtask

   initial begin
      key = 2'b10;
      sw  = 4'b0000;
      hws.READDATA    = '0;
      hws.WAITREQUEST = 1'b0;

      // Reset held for 6 cycles
      for (int i = 0; i < 6; i++) begin
         tick();
         check_reset_outputs("reset");
      end
      check("clk_fwd_low", vid.CLK, 0);
      check("hws_addr",  hws.ADDRESS,   0);
      check("hws_read",  hws.READ,      0);
      check("hws_write", hws.WRITE,     0);
      check("hws_wdata", hws.WRITEDATA, 0);

      // Release
      key = 2'b11;
      t = 0; blank_cnt = 0; blank_rgb_bad = 0;

      // LED[0] blink with a 10-cycle half period
      run_to(9);  check("led0_t9",  led[0], 0);
      tick();     check("led0_t10", led[0], 1);
      run_to(19); check("led0_t19", led[0], 1);
      tick();     check("led0_t20", led[0], 0);
      check("led_3_2", led[3:2], 0);

      // Horizontal timing
      wait_for(0, 1'b0, 400, "hs_fall_seen");
      check("hs_fall_t", t, 41);
      wait_for(0, 1'b1, 400, "hs_rise_seen");
      check("hs_low_len", t - 41, 40);
      wait_for(0, 1'b0, 400, "hs_fall2_seen");
      check("hs_period", t - 41, 280);

      // Vertical timing
      wait_for(1, 1'b0, 40000, "vs_fall_seen");
      check("vs_fall_t", t, 3641);
      wait_for(1, 1'b1, 2000, "vs_rise_seen");
      check("vs_low_len", t - 3641, 840);

      // Grid pattern
      wait_for(2, 1'b1, 40000, "blank_rise_seen");
      check("first_active_t", t, 12721);
      check("grid_0_0", vid.RGB, 24'hFFFFFF);
      tick();        check("grid_1_0", vid.RGB, 24'hFFFFFF);
      run_to(12880); check("grid_159_0_blank", vid.BLANK, 1);
      tick();        check("line_end_blank", vid.BLANK, 0);
      run_to(13002); check("grid_1_1", vid.RGB, 24'h000000);
      check("grid_1_1_blank", vid.BLANK, 1);
      run_to(14136); check("grid_15_5", vid.RGB, 24'h000000);
      tick();        check("grid_16_5", vid.RGB, 24'hFFFFFF);

      // Frame toggle and whole-frame blank accounting
      run_to(37799); check("led1_before_wrap", led[1], 0);
      tick();        check("led1_after_wrap", led[1], 1);
      check("blank_per_frame", blank_cnt, 14400);
      check("rgb_zero_in_blank", blank_rgb_bad, 0);
      wait_for(1, 1'b0, 10000, "vs_fall2_seen");
      check("vs_period", t - 3641, 37800);

      // Colour bars
      sw = 4'b0001;
      check("sw_led_before", led[7:4], 0);
      tick();
      check("sw_led_after", led[7:4], 4'b0001);
      wait_for(2, 1'b1, 40000, "bars_active_seen");
      check("bars_active_t", t, 50521);
      check("bar_px0",   vid.RGB, 24'hFFFFFF);
      run_to(50540); check("bar_px19",  vid.RGB, 24'hFFFFFF);
      tick();        check("bar_px20",  vid.RGB, 24'hFFFF00);
      run_to(50561); check("bar_px40",  vid.RGB, 24'h00FFFF);
      run_to(50581); check("bar_px60",  vid.RGB, 24'h00FF00);
      run_to(50660); check("bar_px139", vid.RGB, 24'h0000FF);
      run_to(50680); check("bar_px159", vid.RGB, 24'h000000);
      check("bar_px159_blank", vid.BLANK, 1);

      // Mid-frame reset
      key = 2'b10;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_reset_outputs("midreset");
      end
      key = 2'b11;
      t = 0;
      tick();
      check("sw_led_after_reset", led[7:4], 4'b0001);
      wait_for(0, 1'b0, 400, "hs_fall_after_reset_seen");
      check("hs_fall_after_reset_t", t, 41);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
